// File: rtl/dmem_defs_pkg.sv
// rtl/dmem_defs_pkg.sv - shared state encoding and default sizing for the dmem responder
package dmem_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_DEPTH       = 32;
  localparam int DEF_ADDR_W      = 5;
  localparam int DEF_WAIT_CYCLES = 1;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM with registered, write-through read port
module dmem_array #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Storage is deliberately never reset; only the read register is.
  always_ff @(posedge i_clock) begin
    if (i_en && i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= i_we ? i_wdata : r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory responder: req/ack handshake, wait states, word array
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_defs_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        i_clock,
  input  logic        i_resetn,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic        o_err
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_idx;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic               w_access;
  logic               w_en;
  logic               w_we;
  logic [31:0]        w_arr_rdata;
  logic               w_unused_addr;

  assign w_unused_addr = ^{i_addr[31:ADDR_W+2], i_addr[1:0]};

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && i_req) begin
        r_cnt   <= CNT_W'(WAIT_CYCLES);
        r_idx   <= i_addr[ADDR_W+1:2];
        r_we    <= i_we;
        r_wdata <= i_wdata;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_req) w_next = ST_WAIT;
      ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_access = (r_state == ST_WAIT) && (r_cnt == '0);
  // A reset landing on the access edge must abort the write too.
  assign w_en     = w_access && i_resetn;
  assign o_ack    = (r_state == ST_RESP);
  assign o_busy   = (r_state != ST_IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_misalign;
  logic r_bad;

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_misalign <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && i_req) begin
        r_misalign <= (i_addr[1:0] != 2'b00);
      end
      if (w_access) begin
        r_bad <= r_misalign;
      end
    end
  end

  assign w_we    = r_we && !r_misalign;
  assign o_rdata = r_bad ? 32'd0 : w_arr_rdata;
  assign o_err   = o_ack && r_bad;
`else
  assign w_we    = r_we;
  assign o_rdata = w_arr_rdata;
  assign o_err   = 1'b0;
`endif

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clock  (i_clock),
    .i_resetn (i_resetn),
    .i_en     (w_en),
    .i_we     (w_we),
    .i_idx    (r_idx),
    .i_wdata  (r_wdata),
    .o_rdata  (w_arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench: directed table, multi-cycle corner cases, random vs model
module tb_dmem_responder;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req1 = 1'b0;
  logic        req0 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ack1, busy1, err1, ack0, busy0, err0;
  logic [31:0] rdata1, rdata0;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem1 [DEPTH];
  logic [31:0] mem0 [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut1 (
    .i_clock(clk), .i_resetn(resetn), .i_req(req1), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_ack(ack1), .o_rdata(rdata1), .o_busy(busy1), .o_err(err1)
  );

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
    .i_clock(clk), .i_resetn(resetn), .i_req(req0), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_ack(ack0), .o_rdata(rdata0), .o_busy(busy0), .o_err(err0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: word index wraps modulo DEPTH, misaligned accesses are void when checked.
  task automatic model(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] er, output logic ee);
    int idx;
    idx = (a / 4) % DEPTH;
    ee  = 1'b0;
    if (ALIGN && (a % 4) != 0) begin
      er = 32'd0;
      ee = 1'b1;
    end else if (w) begin
      if (sel == 1) mem1[idx] = d;
      else          mem0[idx] = d;
      er = d;
    end else begin
      er = (sel == 1) ? mem1[idx] : mem0[idx];
    end
  endtask

  task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input string tag);
    int k;
    int lat;
    bit got;
    @(negedge clk);
    we = w; addr = a; wdata = d;
    if (sel == 1) req1 = 1'b1; else req0 = 1'b1;
    lat = (sel == 1) ? 3 : 2;
    k = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        we = ~w; addr = $urandom; wdata = $urandom;
      end
      if (((sel == 1) ? ack1 : ack0) === 1'b1) got = 1'b1;
      else chk({tag, " err_idle"}, (sel == 1) ? err1 : err0, 32'd0);
    end
    req1 = 1'b0;
    req0 = 1'b0;
    chk({tag, " latency"}, k, lat);
    chk({tag, " rdata"}, (sel == 1) ? rdata1 : rdata0, er);
    chk({tag, " err"}, (sel == 1) ? err1 : err0, {31'd0, ee});
  endtask

  initial begin
    vec_t        tbl [7];
    logic [31:0] er, v;
    logic        ee;

    tbl[0] = '{1'b1, 32'h08, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h00, 32'h12345678, 32'h12345678, 1'b0};
    tbl[3] = '{1'b0, 32'h80, 32'h0, 32'h12345678, 1'b0};
    tbl[4] = ALIGN ? '{1'b1, 32'h0A, 32'hCAFEF00D, 32'h0, 1'b1}
                   : '{1'b1, 32'h0A, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    tbl[5] = '{1'b0, 32'h08, 32'h0, ALIGN ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0};
    tbl[6] = '{1'b0, 32'hFFFFFF88, 32'h0, ALIGN ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0};

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset ack1", ack1, 0);
      chk("reset busy1", busy1, 0);
      chk("reset rdata1", rdata1, 0);
      chk("reset err1", err1, 0);
      chk("reset ack0", ack0, 0);
      chk("reset busy0", busy0, 0);
    end

    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      model(1, 1'b1, i * 4, v, er, ee);
      access(1, 1'b1, i * 4, v, er, ee, "init");
    end

    for (int i = 0; i < 7; i++) begin
      model(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, er, ee);
      access(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err,
             $sformatf("tbl%0d", i));
    end

    // Reset during WAIT aborts the store.
    @(negedge clk);
    we = 1'b1; addr = 32'h10; wdata = 32'hA5A5A5A5; req1 = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    req1 = 1'b0;
    chk("abort ack", ack1, 0);
    chk("abort busy", busy1, 0);
    chk("abort rdata", rdata1, 0);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no ack", ack1, 0);
    end
    model(1, 1'b0, 32'h10, 32'h0, er, ee);
    access(1, 1'b0, 32'h10, 32'h0, er, ee, "abort reload");

    // Reset in RESP: write already committed, ack drops.
    @(negedge clk);
    we = 1'b1; addr = 32'h14; wdata = 32'h5EED1234; req1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("resp ack", ack1, 1);
    resetn = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("resp reset ack", ack1, 0);
    resetn = 1'b1;
    model(1, 1'b1, 32'h14, 32'h5EED1234, er, ee);
    model(1, 1'b0, 32'h14, 32'h0, er, ee);
    access(1, 1'b0, 32'h14, 32'h0, er, ee, "resp reload");

    // WAIT_CYCLES=0 with req held: ack every third cycle.
    model(0, 1'b1, 32'h04, 32'h0BADF00D, er, ee);
    access(0, 1'b1, 32'h04, 32'h0BADF00D, er, ee, "w0 store");
    @(negedge clk);
    we = 1'b0; addr = 32'h04; req0 = 1'b1;
    chk("b2b busy0 k0", busy0, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("b2b ack k%0d", k), ack0, ((k % 3) == 2) ? 1 : 0);
      chk($sformatf("b2b busy k%0d", k), busy0, ((k % 3) != 0) ? 1 : 0);
      if ((k % 3) == 2) chk($sformatf("b2b rdata k%0d", k), rdata0, 32'h0BADF00D);
    end
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b idle", busy0, 0);

    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [31:0] a, d;
      w = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d = $urandom;
      model(1, w, a, d, er, ee);
      access(1, w, a, d, er, ee, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
